// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word width, PC step, reset defaults and the IF/ID payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_stage_incr.sv
// PC incrementor: pc + 4, modulo 2^32 with no carry-out.
module pc_fetch_stage_incr
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc4
);

  assign pc4 = WORD_W'(pc + PC_STEP);

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional macro PC_ALIGN_CHECK_EN adds a sticky flag for misaligned redirect targets.
module pc_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              misalign_err
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] pc4;
  if_id_t            if_id;
  if_id_t            if_id_next;

  pc_fetch_stage_incr u_incr (
    .pc  (pc),
    .pc4 (pc4)
  );

  // Redirect beats stall; a redirect always leaves a bubble in IF/ID.
  always_comb begin
    pc_next    = pc;
    if_id_next = if_id;
    if (redirect) begin
      pc_next          = word_align(redirect_target);
      if_id_next.instr = NOP_INSTR;
      if_id_next.pc4   = '0;
      if_id_next.valid = 1'b0;
    end else if (!stall) begin
      pc_next          = pc4;
      if_id_next.instr = imem_rdata;
      if_id_next.pc4   = pc4;
      if_id_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id.instr <= NOP_INSTR;
      if_id.pc4   <= '0;
      if_id.valid <= 1'b0;
    end else begin
      pc    <= pc_next;
      if_id <= if_id_next;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;

  // Sticky until reset; the PC itself still takes the masked target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: per-cycle reference model plus directed literal checks.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  pc_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model state, updated from the behavioural rules.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (redirect) begin
      if (MIS_EN && redirect_target % 4 != 0) m_mis = 1'b1;
      m_pc = redirect_target - (redirect_target % 4);
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_imem_addr", imem_addr, m_pc);
    chk("cyc_instr", if_id_instr, m_instr);
    chk("cyc_pc4", if_id_pc4, m_pc4);
    chk("cyc_valid", 32'(if_id_valid), 32'(m_valid));
    chk("cyc_misalign", 32'(misalign_err), 32'(m_mis));
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    rst = 1'b0;

    // Free run from reset.
    @(negedge clk);
    chk("run1_pc4", if_id_pc4, 32'd4);
    chk("run1_valid", 32'(if_id_valid), 32'd1);
    chk("run1_addr", imem_addr, 32'd4);
    chk("run1_instr", if_id_instr, mem_word(32'd0));
    @(negedge clk);
    chk("run2_pc4", if_id_pc4, 32'd8);
    chk("run2_addr", imem_addr, 32'd8);

    // Stall three cycles at pc=8.
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_addr", imem_addr, 32'd8);
    chk("stall_pc4", if_id_pc4, 32'd8);
    chk("stall_instr", if_id_instr, mem_word(32'd4));
    stall = 1'b0;
    @(negedge clk);
    chk("resume_addr", imem_addr, 32'd12);
    chk("resume_pc4", if_id_pc4, 32'd12);

    // Redirect together with stall.
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0040;
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_instr", if_id_instr, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    chk("redir_next_pc4", if_id_pc4, 32'h44);
    chk("redir_next_valid", 32'(if_id_valid), 32'h1);

    // Wrap past the top of the address space.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_valid", 32'(if_id_valid), 32'h1);

    // Misaligned target, then an aligned one.
    redirect = 1'b1; redirect_target = 32'h0000_0023;
    @(negedge clk);
    chk("mis_addr", imem_addr, 32'h20);
    chk("mis_flag", 32'(misalign_err), 32'(MIS_EN));
    redirect_target = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("mis_sticky", 32'(misalign_err), 32'(MIS_EN));
    chk("aligned_pc4", if_id_pc4, 32'h104);

    // Mixed stall/redirect traffic checked by the model.
    for (int i = 0; i < 40; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      redirect_target = $urandom;
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", 32'(if_id_valid), 32'h0);
    chk("arst_pc4", if_id_pc4, 32'h0);
    chk("arst_instr", if_id_instr, 32'h0);
    chk("arst_mis", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_arst_pc4", if_id_pc4, 32'd4);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
